clock_set_controller: RTL and testbench

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

---
 rtl/clock_set_controller.sv | 212 +++++++++++++++++++++
 tb/tb_clock_set_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// UART command parser that turns "Thhmmss\r" / "Dddmmyyyy\r" / "S" into calendar
// load requests (validated, with ack handshake and timeout) and pause pulses.
module clock_set_controller #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_data,
  input  logic        uart_valid,
  input  logic        load_ack,
  output logic        load_req,
  output logic        load_sel,
  output logic [7:0]  set_hour,
  output logic [7:0]  set_minute,
  output logic [7:0]  set_second,
  output logic [4:0]  set_day,
  output logic [3:0]  set_month,
  output logic [11:0] set_year,
  output logic        pause_toggle,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, DIGITS, WAIT_CR, CHECK, REQ} state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cmd_q, cmd_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        pause_q, pause_d;
  logic        load_d;
  logic        sel_q;
  logic [7:0]  hour_q, min_q, sec_q;
  logic [4:0]  day_q;
  logic [3:0]  mon_q;
  logic [11:0] year_q;

  function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
    return {3'b000, tens} * 7'd10 + {3'b000, ones};
  endfunction

  // Year is split as century*100 + yy, so the leap rules reduce to mod-4 tests.
  function automatic logic is_leap(input logic [6:0] cc, input logic [6:0] yy);
    return (yy != 7'd0) ? (yy[1:0] == 2'b00) : (cc[1:0] == 2'b00);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [6:0] month, input logic leap);
    logic [4:0] dim;
    case (month)
      7'd2:                    dim = leap ? 5'd29 : 5'd28;
      7'd4, 7'd6, 7'd9, 7'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
    return dim;
  endfunction

  logic [6:0]  c_hour, c_min, c_sec, c_day, c_mon, c_cc, c_yy;
  logic [13:0] c_year;
  logic [4:0]  c_dim;
  logic        time_ok, date_ok, chk_ok;
  logic        is_digit;
  logic [3:0]  need, cnt_inc;

  assign c_hour  = bcd2bin(buf_q[23:20], buf_q[19:16]);
  assign c_min   = bcd2bin(buf_q[15:12], buf_q[11:8]);
  assign c_sec   = bcd2bin(buf_q[7:4],   buf_q[3:0]);
  assign c_day   = bcd2bin(buf_q[31:28], buf_q[27:24]);
  assign c_mon   = bcd2bin(buf_q[23:20], buf_q[19:16]);
  assign c_cc    = bcd2bin(buf_q[15:12], buf_q[11:8]);
  assign c_yy    = bcd2bin(buf_q[7:4],   buf_q[3:0]);
  assign c_year  = {7'b0, c_cc} * 14'd100 + {7'b0, c_yy};
  assign c_dim   = days_in_month(c_mon, is_leap(c_cc, c_yy));
  assign time_ok = (c_hour <= 7'd23) && (c_min <= 7'd59) && (c_sec <= 7'd59);
  assign date_ok = (c_mon >= 7'd1) && (c_mon <= 7'd12) && (c_year <= 14'd4095) &&
                   (c_day >= 7'd1) && (c_day <= {2'b00, c_dim});
  assign chk_ok  = cmd_q ? date_ok : time_ok;

  assign is_digit = (uart_data >= 8'h30) && (uart_data <= 8'h39);
  assign need     = cmd_q ? 4'd8 : 4'd6;
  assign cnt_inc  = cnt_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    pause_d = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (uart_valid) begin
          if (uart_data == 8'h54 || uart_data == 8'h44) begin
            state_d = DIGITS;
            cmd_d   = (uart_data == 8'h44);
            buf_d   = '0;
            cnt_d   = '0;
          end else if (uart_data == 8'h53) begin
            pause_d = 1'b1;
          end
        end
      end
      DIGITS: begin
        if (uart_valid) begin
          if (is_digit) begin
            buf_d = {buf_q[27:0], uart_data[3:0]};
            cnt_d = cnt_inc;
            if (cnt_inc == need) state_d = WAIT_CR;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_CR: begin
        if (uart_valid) begin
          if (uart_data == 8'h0D) begin
            state_d = CHECK;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      CHECK: begin
        if (chk_ok) begin
          state_d = REQ;
          tmo_d   = '0;
          load_d  = 1'b1;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      REQ: begin
        if (load_ack) begin
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    load_req = (state_q == REQ);
  end

  // Field registers only change on the CHECK->REQ step, and only for the selected group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      pause_q <= 1'b0;
      sel_q   <= 1'b0;
      hour_q  <= 8'd18;
      min_q   <= 8'd30;
      sec_q   <= 8'd0;
      day_q   <= 5'd30;
      mon_q   <= 4'd7;
      year_q  <= 12'd2024;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      pause_q <= pause_d;
      if (load_d) begin
        sel_q <= cmd_q;
        if (cmd_q) begin
          day_q  <= c_day[4:0];
          mon_q  <= c_mon[3:0];
          year_q <= c_year[11:0];
        end else begin
          hour_q <= {1'b0, c_hour};
          min_q  <= {1'b0, c_min};
          sec_q  <= {1'b0, c_sec};
        end
      end
    end
  end

  assign load_sel     = sel_q;
  assign set_hour     = hour_q;
  assign set_minute   = min_q;
  assign set_second   = sec_q;
  assign set_day      = day_q;
  assign set_month    = mon_q;
  assign set_year     = year_q;
  assign err          = err_q;
  assign pause_toggle = pause_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: vector table, hand-written corner sequences and
// random commands checked against a command-level reference model.
module tb_clock_set_controller;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  uart_data = 8'h00;
  logic        uart_valid = 1'b0;
  logic        load_ack = 1'b0;
  logic        load_req, load_sel, pause_toggle, busy, err;
  logic [7:0]  set_hour, set_minute, set_second;
  logic [4:0]  set_day;
  logic [3:0]  set_month;
  logic [11:0] set_year;

  clock_set_controller #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .uart_data(uart_data), .uart_valid(uart_valid),
    .load_ack(load_ack), .load_req(load_req), .load_sel(load_sel),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .pause_toggle(pause_toggle), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int err_seen = 0, pause_seen = 0, req_rises = 0, req_hi = 0;
  logic prev_req = 1'b0;
  logic [44:0] cap = '0;
  logic cap_sel = 1'b0;
  int mh = 18, mm = 30, ms = 0, md = 30, mmo = 7, my = 2024;

  typedef struct {
    string cmd;
    int    ack;
    bit    e_err;
    bit    e_load;
    bit    e_sel;
    int    h, mi, s, d, mo, y;
  } vec_t;
  vec_t vq[$];

  function automatic logic [44:0] pack(input int h, input int mi, input int s,
                                       input int d, input int mo, input int y);
    return {8'(h), 8'(mi), 8'(s), 5'(d), 4'(mo), 12'(y)};
  endfunction

  function automatic logic [44:0] fields_now();
    return {set_hour, set_minute, set_second, set_day, set_month, set_year};
  endfunction

  always @(negedge clk) begin
    if (err) err_seen++;
    if (pause_toggle) pause_seen++;
    if (load_req) req_hi++;
    if (load_req && !prev_req) begin
      req_rises++;
      cap     = fields_now();
      cap_sel = load_sel;
    end
    prev_req = load_req;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_data  = b;
    uart_valid = 1'b1;
    @(negedge clk);
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    @(negedge clk);
  endtask

  task automatic run_cmd(input string s, input int ack, input bit s_in_req);
    int w;
    for (int i = 0; i < s.len(); i++) send_byte(s.getc(i));
    w = 0;
    while (!load_req && w < 3) begin @(negedge clk); w++; end
    if (load_req) begin
      if (s_in_req) send_byte(8'h53);
      if (ack >= 0) begin
        repeat (ack) @(negedge clk);
        chk("req_hold", load_req, 1);
        load_ack = 1'b1;
        @(negedge clk);
        load_ack = 1'b0;
        chk("req_drop_after_ack", load_req, 0);
      end else begin
        w = 0;
        while (load_req && w < 300) begin @(negedge clk); w++; end
        chk("req_timeout_bound", load_req, 0);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic add_vec(input string c, input int ack, input bit ee, input bit el, input bit es,
                         input int h, input int mi, input int s, input int d, input int mo, input int y);
    vec_t v;
    v.cmd = c; v.ack = ack; v.e_err = ee; v.e_load = el; v.e_sel = es;
    v.h = h; v.mi = mi; v.s = s; v.d = d; v.mo = mo; v.y = y;
    vq.push_back(v);
  endtask

  function automatic int dg(input string s, input int i);
    return int'(s.getc(i)) - 48;
  endfunction

  // Command-level reference: parse the whole string, then apply the calendar rules.
  function automatic void model_cmd(input string s, output bit ok, output bit isd,
                                    output int a, output int b, output int c);
    int n, dim;
    bit leap;
    int mdays[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    ok = 1'b1; a = 0; b = 0; c = 0;
    isd = (s.getc(0) == 8'h44);
    n = isd ? 8 : 6;
    if (s.len() != n + 2) begin ok = 1'b0; return; end
    for (int i = 1; i <= n; i++)
      if (s.getc(i) < 8'h30 || s.getc(i) > 8'h39) ok = 1'b0;
    if (s.getc(n + 1) != 8'h0D) ok = 1'b0;
    if (!ok) return;
    a = dg(s, 1) * 10 + dg(s, 2);
    b = dg(s, 3) * 10 + dg(s, 4);
    if (isd) c = dg(s, 5) * 1000 + dg(s, 6) * 100 + dg(s, 7) * 10 + dg(s, 8);
    else     c = dg(s, 5) * 10 + dg(s, 6);
    if (!isd) begin
      ok = (a <= 23) && (b <= 59) && (c <= 59);
    end else begin
      if (b < 1 || b > 12 || c > 4095) begin ok = 1'b0; return; end
      leap = ((c % 4 == 0) && (c % 100 != 0)) || (c % 400 == 0);
      dim  = (b == 2 && leap) ? 29 : mdays[b - 1];
      ok   = (a >= 1) && (a <= dim);
    end
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, p0;
    logic [7:0] junk[7] = '{8'h61, 8'h54, 8'h53, 8'h44, 8'h58, 8'h0D, 8'h35};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_load_req", load_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_pause", pause_toggle, 0);
    chk("rst_load_sel", load_sel, 0);
    chk("rst_fields", fields_now(), pack(18, 30, 0, 30, 7, 2024));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    add_vec("T183045\015",   3, 0, 1, 0, 18, 30, 45, 30,  7, 2024);
    add_vec("D29022024\015", 1, 0, 1, 1, 18, 30, 45, 29,  2, 2024);
    add_vec("D29022023\015", 0, 1, 0, 0, 18, 30, 45, 29,  2, 2024);
    add_vec("T240000\015",   0, 1, 0, 0, 18, 30, 45, 29,  2, 2024);
    add_vec("T12a\015",      0, 1, 0, 0, 18, 30, 45, 29,  2, 2024);
    add_vec("T123456X",      0, 1, 0, 0, 18, 30, 45, 29,  2, 2024);
    add_vec("D31042024\015", 0, 1, 0, 0, 18, 30, 45, 29,  2, 2024);
    add_vec("D29022000\015", 0, 0, 1, 1, 18, 30, 45, 29,  2, 2000);
    add_vec("D29021900\015", 0, 1, 0, 0, 18, 30, 45, 29,  2, 2000);
    add_vec("T235959\015",   2, 0, 1, 0, 23, 59, 59, 29,  2, 2000);
    add_vec("D01014095\015", 5, 0, 1, 1, 23, 59, 59,  1,  1, 4095);
    add_vec("D01014096\015", 0, 1, 0, 0, 23, 59, 59,  1,  1, 4095);
    add_vec("T000060\015",   0, 1, 0, 0, 23, 59, 59,  1,  1, 4095);
    add_vec("D00012024\015", 0, 1, 0, 0, 23, 59, 59,  1,  1, 4095);
    add_vec("D01132024\015", 0, 1, 0, 0, 23, 59, 59,  1,  1, 4095);
    add_vec("D30022024\015", 0, 1, 0, 0, 23, 59, 59,  1,  1, 4095);
    add_vec("X",             0, 0, 0, 0, 23, 59, 59,  1,  1, 4095);
    add_vec("TS",            0, 1, 0, 0, 23, 59, 59,  1,  1, 4095);
    add_vec("T1D",           0, 1, 0, 0, 23, 59, 59,  1,  1, 4095);
    add_vec("D31122024\015", -1, 1, 1, 1, 23, 59, 59, 31, 12, 2024);

    foreach (vq[i]) begin
      e0 = err_seen; r0 = req_rises; p0 = pause_seen; req_hi = 0;
      run_cmd(vq[i].cmd, vq[i].ack, 1'b0);
      chk($sformatf("v%0d_err", i), err_seen - e0, vq[i].e_err);
      chk($sformatf("v%0d_req", i), req_rises - r0, vq[i].e_load);
      chk($sformatf("v%0d_pause", i), pause_seen - p0, 0);
      if (vq[i].e_load) begin
        chk($sformatf("v%0d_fields_at_req", i), cap,
            pack(vq[i].h, vq[i].mi, vq[i].s, vq[i].d, vq[i].mo, vq[i].y));
        chk($sformatf("v%0d_sel", i), cap_sel, vq[i].e_sel);
      end
      if (vq[i].ack < 0 && vq[i].e_load)
        chk($sformatf("v%0d_req_cycles", i), req_hi, TMO);
      chk($sformatf("v%0d_fields", i), fields_now(),
          pack(vq[i].h, vq[i].mi, vq[i].s, vq[i].d, vq[i].mo, vq[i].y));
      chk($sformatf("v%0d_busy", i), busy, 0);
      mh = vq[i].h; mm = vq[i].mi; ms = vq[i].s; md = vq[i].d; mmo = vq[i].mo; my = vq[i].y;
    end

    // 'S' in IDLE: exactly one pulse, the cycle after the byte
    p0 = pause_seen;
    uart_data = 8'h53; uart_valid = 1'b1;
    @(negedge clk);
    uart_valid = 1'b0; uart_data = 8'h00;
    chk("pause_pulse", pause_toggle, 1);
    @(negedge clk);
    chk("pause_clear", pause_toggle, 0);
    repeat (2) @(negedge clk);
    chk("pause_count", pause_seen - p0, 1);

    // 'S' while a load is pending is dropped
    e0 = err_seen; r0 = req_rises; p0 = pause_seen;
    run_cmd("T101010\015", 2, 1'b1);
    mh = 10; mm = 10; ms = 10;
    chk("s_in_req_pause", pause_seen - p0, 0);
    chk("s_in_req_err", err_seen - e0, 0);
    chk("s_in_req_fields", fields_now(), pack(mh, mm, ms, md, mmo, my));

    // load_ack in IDLE is ignored
    e0 = err_seen; r0 = req_rises;
    load_ack = 1'b1;
    repeat (3) @(negedge clk);
    load_ack = 1'b0;
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_req", req_rises - r0, 0);
    chk("idle_ack_err", err_seen - e0, 0);

    // Reset mid-command
    e0 = err_seen;
    send_byte(8'h54); send_byte(8'h31); send_byte(8'h32);
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy_async", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_fields", fields_now(), pack(18, 30, 0, 30, 7, 2024));
    chk("abort_err", err_seen - e0, 0);
    chk("abort_busy_after", busy, 0);

    // Reset during a pending load
    e0 = err_seen;
    for (int i = 0; i < 8; i++) send_byte(8'("T010203\015" >> (8 * (7 - i))));
    chk("reqabort_req_before", load_req, 1);
    rst = 1'b1;
    #1;
    chk("reqabort_req_async", load_req, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reqabort_fields", fields_now(), pack(18, 30, 0, 30, 7, 2024));
    chk("reqabort_err", err_seen - e0, 0);
    chk("reqabort_sel", load_sel, 0);
    mh = 18; mm = 30; ms = 0; md = 30; mmo = 7; my = 2024;

    // Random commands against the reference model
    for (int k = 0; k < 50; k++) begin
      string s;
      int ack, a, b, c, ye;
      bit ok, isd, sir, is_s;
      is_s = ($urandom_range(0, 9) == 0);
      if (is_s) begin
        s = "S"; ack = 0; sir = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 5))
            0: ye = 2000; 1: ye = 1900; 2: ye = 2100; 3: ye = 2400; 4: ye = 2023;
            default: ye = $urandom_range(0, 4200);
          endcase
          s = $sformatf("D%02d%02d%04d\015", $urandom_range(0, 32), $urandom_range(0, 13), ye);
        end else begin
          s = $sformatf("T%02d%02d%02d\015", $urandom_range(0, 25), $urandom_range(0, 61),
                        $urandom_range(0, 61));
        end
        if ($urandom_range(0, 5) == 0)
          s.putc($urandom_range(1, s.len() - 1), junk[$urandom_range(0, 6)]);
        ack = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 4);
        sir = ($urandom_range(0, 3) == 0);
      end
      e0 = err_seen; r0 = req_rises; p0 = pause_seen;
      run_cmd(s, ack, sir);
      if (is_s) begin
        ok = 1'b0;
      end else begin
        model_cmd(s, ok, isd, a, b, c);
        if (ok) begin
          if (isd) begin md = a; mmo = b; my = c; end
          else     begin mh = a; mm = b; ms = c; end
        end
      end
      chk($sformatf("r%0d_err", k), err_seen - e0, (!is_s && (!ok || ack < 0)) ? 1 : 0);
      chk($sformatf("r%0d_req", k), req_rises - r0, ok ? 1 : 0);
      chk($sformatf("r%0d_pause", k), pause_seen - p0, is_s ? 1 : 0);
      chk($sformatf("r%0d_fields", k), fields_now(), pack(mh, mm, ms, md, mmo, my));
      if (ok) chk($sformatf("r%0d_sel", k), cap_sel, isd);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
